// File: rtl/de1_soc_key_conditioner.sv
// Per-channel pin conditioner: 2-flop sync, debounce, press/release/auto-repeat strobes.
// Latency DEBOUNCE_CYC+2 cycles pin-to-LEVEL; outputs registered, no backpressure (strobes are fire-and-forget).
module de1_soc_key_conditioner #(
    parameter int N_CH          = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic [N_CH-1:0] RAW_IN,
    input  logic [N_CH-1:0] REPEAT_EN,
    output logic [N_CH-1:0] LEVEL,
    output logic [N_CH-1:0] PRESS,
    output logic [N_CH-1:0] RELEASE,
    output logic [N_CH-1:0] REPEAT
);

    localparam int MAX_DR  = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
    localparam int MAX_CYC = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] act;

    // Synchroniser idles at the inactive pin level so reset exit is silent.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= {N_CH{ACTIVE_LOW}};
            sync2 <= {N_CH{ACTIVE_LOW}};
        end else begin
            sync1 <= RAW_IN;
            sync2 <= sync1;
        end
    end

    assign act = sync2 ^ {N_CH{ACTIVE_LOW}};

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [CW-1:0] db_cnt;
        logic [CW-1:0] rp_cnt;
        rpt_state_t    state;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;
        logic          flip;
        logic          rise;
        logic          fall;

        assign flip = (act[ch] != level_q) && (db_cnt == DB_LAST);
        assign rise = flip && !level_q;
        assign fall = flip && level_q;

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rise;
                release_q <= fall;
                if (act[ch] == level_q || flip) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CW'(1);
                end
                if (flip) begin
                    level_q <= ~level_q;
                end
            end
        end

        // The FSM keys off the debounce transition itself so the first
        // repeat lands exactly REPEAT_DELAY cycles after the PRESS strobe.
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                state    <= IDLE;
                rp_cnt   <= '0;
                repeat_q <= 1'b0;
            end else begin
                repeat_q <= 1'b0;
                if (fall || !REPEAT_EN[ch]) begin
                    state  <= IDLE;
                    rp_cnt <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            rp_cnt <= '0;
                            if (rise) begin
                                state <= DELAY;
                            end
                        end
                        DELAY: begin
                            if (rp_cnt == RD_LAST) begin
                                repeat_q <= 1'b1;
                                rp_cnt   <= '0;
                                state    <= RPT;
                            end else begin
                                rp_cnt <= rp_cnt + CW'(1);
                            end
                        end
                        RPT: begin
                            if (rp_cnt == RP_LAST) begin
                                repeat_q <= 1'b1;
                                rp_cnt   <= '0;
                            end else begin
                                rp_cnt <= rp_cnt + CW'(1);
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            rp_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign LEVEL[ch]   = level_q;
        assign PRESS[ch]   = press_q;
        assign RELEASE[ch] = release_q;
        assign REPEAT[ch]  = repeat_q;
    end

endmodule

// File: doc/de1_soc_key_conditioner.md
# de1_soc_key_conditioner

Parametrised input conditioner for the DE1-SoC pushbuttons and slide switches. Per channel it synchronises the raw pin, debounces it and produces a clean level, one-cycle press and release strobes, and an optional auto-repeat strobe. It sits between the top-level `KEY`/`SW` pins and user logic, replacing ad-hoc per-design button handling.

## Interface
- `N_CH`, 4, number of independent channels.
- `ACTIVE_LOW`, 1, 1: raw pin low means pressed (KEY); 0: raw high means pressed (SW).
- `DEBOUNCE_CYC`, 250000, consecutive stable cycles required to accept a change (5 ms at 50 MHz); ≥1.
- `REPEAT_DELAY`, 25000000, cycles from PRESS to first REPEAT; ≥1.
- `REPEAT_PERIOD`, 5000000, cycles between subsequent REPEATs; ≥1.
- Counter widths derive from the maximum of the three cycle parameters via `$clog2`.

Ports:
- `CLOCK_50`  in  1  system clock. All logic is rising-edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `RAW_IN`  in  N_CH  raw asynchronous pin inputs.
- `REPEAT_EN`  in  N_CH  per-channel auto-repeat enable; synchronous to `CLOCK_50`.
- `LEVEL`  out  N_CH  debounced state, 1 = pressed, registered.
- `PRESS`  out  N_CH  one-cycle strobe on an accepted inactive→active change.
- `RELEASE`  out  N_CH  one-cycle strobe on an accepted active→inactive change.
- `REPEAT`  out  N_CH  one-cycle auto-repeat strobe.

## Operation
- **Reset values.** All outputs are 0. Both synchroniser flops reset to the inactive raw value: 1 if `ACTIVE_LOW`, else 0. Debounce and repeat counters reset to 0. Repeat FSMs reset to IDLE. No strobe fires on reset exit when the pins are inactive.
- **Synchroniser.** There is a 2-flop synchroniser per channel. The polarity is normalised after it: `act = sync2 ^ ACTIVE_LOW`.
- **Debounce.**
  - When `act != LEVEL`, the channel counter increments.
  - When `act == LEVEL`, the counter clears to 0.
  - When `act != LEVEL` and the counter equals `DEBOUNCE_CYC-1`:
    - `LEVEL` toggles.
    - The counter clears.
    - `PRESS` (new level 1) or `RELEASE` (new level 0) is asserted in the same cycle that `LEVEL` changes.
  - A mismatch lasting fewer than `DEBOUNCE_CYC` consecutive cycles produces no change and no strobe.
- **Repeat FSM** (per channel; states IDLE, DELAY, RPT):
  - IDLE→DELAY on `PRESS` when `REPEAT_EN`=1; the counter loads 0.
  - DELAY: the counter increments. When it reaches `REPEAT_DELAY-1`, assert `REPEAT`, clear the counter and go to RPT.
  - RPT: the counter increments. When it reaches `REPEAT_PERIOD-1`, assert `REPEAT` and clear the counter.
  - Any state→IDLE when `LEVEL` falls (`RELEASE` cycle) or `REPEAT_EN`=0. The counter clears and no `REPEAT` fires in that cycle.
  - Asserting `REPEAT_EN` while already held does not start repeat; a new `PRESS` is required.
- **Channel independence.** Channels are fully independent. Simultaneous events on different channels each produce their own strobes in the same cycle.
- **Exclusivity.** `PRESS`, `RELEASE` and `REPEAT` never assert together on one channel.

## Timing
- **Press latency.** Raw edge first sampled at edge 1 gives `act` valid after edge 2. `LEVEL`/`PRESS` assert after edge `DEBOUNCE_CYC+2`. Total latency is `DEBOUNCE_CYC+2` cycles, and release latency is identical.
- **Repeat timing.** With `PRESS` at cycle P:
  - The first `REPEAT` is at cycle P+`REPEAT_DELAY`.
  - Subsequent repeats are at P+`REPEAT_DELAY`+k·`REPEAT_PERIOD`, k≥1.
- **Strobe width.** All strobes are exactly 1 cycle and registered; there are no combinational paths from inputs to outputs.
- **Reset mid-operation.** Asynchronous assertion clears everything immediately. After deassertion a held-active pin produces `PRESS` `DEBOUNCE_CYC+2` cycles later.
- **Counter overflow.** Counters never wrap: every compare clears the counter before it reaches its terminal value.

## Test plan
Test parameters: `N_CH`=4, `DEBOUNCE_CYC`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `ACTIVE_LOW`=1.
1. **Reset with inactive pins.** Hold `RAW_IN`=4'hF through reset and 50 cycles. Required: all outputs 0 and no strobe.
2. **Clean press and release.** Drive `RAW_IN[0]` low at cycle 0. Required: `LEVEL[0]`=1 and `PRESS[0]` pulse at cycle 6. Drive it high at cycle 20. Required: `RELEASE[0]` at cycle 26 and `LEVEL[0]`=0.
3. **Bounce rejection.** Drive `RAW_IN[1]` low for 3 cycles, high for 1, then low steady. Required: no strobe from the 3-cycle glitch, and `PRESS[1]` 6 cycles after the final low.
4. **Auto-repeat.** Set `REPEAT_EN[2]`=1 and hold `RAW_IN[2]` low for 30 cycles after `PRESS` at P. Required: `REPEAT[2]` at P+10, P+13, P+16 …. Release; required: no `REPEAT` on or after the `RELEASE` cycle.
5. **Disable mid-hold.** Repeat case 4, then drop `REPEAT_EN[2]` at P+12. Required: no `REPEAT` at P+13 or later. Re-assert `REPEAT_EN[2]` while still held; required: no `REPEAT` until the next press.
6. **Simultaneous channels and async reset.** Press ch0 and ch3 in the same cycle. Required: `PRESS`=4'b1001 in one cycle. Assert `RESET_N`=0 mid-hold. Required: outputs clear immediately; after release of reset, `PRESS`=4'b1001 again 6 cycles later.
